t_toggle_arbiter: RTL and testbench

Round-robin controller that shares one bank of `WIDTH` toggle flip-flops among `NREQ` requesters. Each requester submits a toggle mask or a clear command through a req/ack handshake. The arbiter grants one requester at a time and applies the command to the bank: q ^= mask, or q = 0 on clear. It sits between the control agents and the T-flip-flop register bank, replacing direct per-agent drive of the `t`/`clr` inputs.

---
 rtl/t_toggle_arbiter.sv | 130 +++++++++++++
 tb/tb_t_toggle_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/t_toggle_arbiter.sv
// Round-robin arbiter sharing one toggle register bank among NREQ requesters.
// Each grant applies either q ^= mask or q = 0, then returns to IDLE.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | sampling req, picking the next winner from the rr pointer
// ST_APPLY | ack/busy high; latched command lands on q at the exit edge
module t_toggle_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       clr_req,
  input  logic [NREQ*WIDTH-1:0] t_mask,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  localparam int IW1 = IDW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             clr_q, clr_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IW1-1:0]   cand;
  logic [WIDTH-1:0] win_mask;
  logic [IDW-1:0]   ptr_inc;

  // Scan upward from the pointer with wrap; first set req bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + IW1'(k);
      if (cand >= IW1'(NREQ)) begin
        cand = cand - IW1'(NREQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  assign win_mask = t_mask[int'(win)*WIDTH +: WIDTH];
  assign ptr_inc  = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    mask_d  = mask_q;
    clr_d   = clr_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        ack_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          grant_d    = win;
          mask_d     = win_mask;
          clr_d      = clr_req[win];
          ack_d[win] = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_APPLY;
        end
      end
      ST_APPLY: begin
        q_d     = clr_q ? '0 : (q_q ^ mask_q);
        ack_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_inc;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      mask_q  <= '0;
      clr_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
      clr_q   <= clr_d;
      ptr_q   <= ptr_d;
    end
  end

  assign q        = q_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_t_toggle_arbiter.sv
// Directed bench for t_toggle_arbiter: reset, single grants, round-robin
// order, clear priority, zero mask and reset in the middle of APPLY.
module tb_t_toggle_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  clr_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       clr_req;
  logic [NREQ*WIDTH-1:0] t_mask;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic [IDW-1:0]        grant_id;

  int passed;
  int total;

  t_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .req      (req),
    .clr_req  (clr_req),
    .t_mask   (t_mask),
    .ack      (ack),
    .q        (q),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int id, input logic [WIDTH-1:0] m, input logic c);
    t_mask[id*WIDTH +: WIDTH] = m;
    clr_req[id] = c;
    req[id] = 1'b1;
  endtask

  // Raise req[id] now, check the grant after the next edge, drop on ack,
  // then check the bank after the applying edge.
  task automatic serve(input string tag, input int id, input logic [WIDTH-1:0] m,
                       input logic c, input logic [WIDTH-1:0] q_exp);
    set_cmd(id, m, c);
    cyc();
    chk({tag, "_ack"}, 32'(ack), 32'(1) << id);
    chk({tag, "_gid"}, 32'(grant_id), 32'(id));
    req[id] = 1'b0;
    cyc();
    chk({tag, "_ackdrop"}, 32'(ack), 32'h0);
    chk({tag, "_q"}, 32'(q), 32'(q_exp));
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    clr_n   = 1'b0;
    req     = 4'b1111;
    clr_req = '0;
    t_mask  = '0;

    // 1. reset
    repeat (3) cyc();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    req   = '0;
    clr_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_stable", {15'h0, busy, 8'(ack), q}, 32'h0);
    end

    // 2. single requester
    set_cmd(1, 8'h0F, 1'b0);
    cyc();
    chk("s1_ack", 32'(ack), 32'h2);
    chk("s1_busy", 32'(busy), 32'h1);
    chk("s1_gid", 32'(grant_id), 32'h1);
    chk("s1_qhold", 32'(q), 32'h00);
    req[1] = 1'b0;
    cyc();
    chk("s1_ackdrop", 32'(ack), 32'h0);
    chk("s1_busydrop", 32'(busy), 32'h0);
    chk("s1_q", 32'(q), 32'h0F);
    serve("s2", 1, 8'h05, 1'b0, 8'h0A);

    // 3. round-robin from a fresh reset (pointer = 0, q = 0)
    clr_n = 1'b0;
    cyc();
    clr_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 8'(1 << i), 1'b0);
    for (int i = 0; i < NREQ; i++) begin
      cyc();
      chk("rr_ack", 32'(ack), 32'(1) << i);
      chk("rr_gid", 32'(grant_id), 32'(i));
      req[i] = 1'b0;
      cyc();
      chk("rr_gap", 32'(ack), 32'h0);
    end
    chk("rr_q", 32'(q), 32'h0F);
    set_cmd(0, 8'h10, 1'b0);
    set_cmd(3, 8'h80, 1'b0);
    cyc();
    chk("wrap_ack0", 32'(ack), 32'h1);
    req[0] = 1'b0;
    cyc();
    chk("wrap_q0", 32'(q), 32'h1F);
    cyc();
    chk("wrap_ack3", 32'(ack), 32'h8);
    chk("wrap_gid3", 32'(grant_id), 32'h3);
    req[3] = 1'b0;
    cyc();
    chk("wrap_q3", 32'(q), 32'h9F);

    // 4. clear priority (lone requester 1 first moves q to 0x5A)
    serve("pre4", 1, 8'hC5, 1'b0, 8'h5A);
    serve("clr", 2, 8'hFF, 1'b1, 8'h00);
    cyc();
    chk("clr_once", 32'(ack), 32'h0);
    clr_req = '0;

    // 5. zero mask
    serve("pre5", 3, 8'h3C, 1'b0, 8'h3C);
    serve("zero", 0, 8'h00, 1'b0, 8'h3C);

    // 6. reset during APPLY
    serve("pre6", 1, 8'h2D, 1'b0, 8'h11);
    set_cmd(3, 8'hF0, 1'b0);
    cyc();
    chk("mid_ack", 32'(ack), 32'h8);
    chk("mid_busy", 32'(busy), 32'h1);
    clr_n = 1'b0;
    #1;
    chk("mid_ackdrop", 32'(ack), 32'h0);
    chk("mid_busydrop", 32'(busy), 32'h0);
    chk("mid_q", 32'(q), 32'h00);
    cyc();
    chk("mid_qheld", 32'(q), 32'h00);
    clr_n = 1'b1;
    cyc();
    chk("post_ack", 32'(ack), 32'h8);
    chk("post_gid", 32'(grant_id), 32'h3);
    req[3] = 1'b0;
    cyc();
    chk("post_q", 32'(q), 32'hF0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
